// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: ALU op codes, widths and the
// state encodings used by mem_access_unit.
package mem_access_unit_pkg;

    localparam int ALU_OP_WIDTH = 8;
    localparam int DATA_WIDTH   = 32;
    localparam int REG_WIDTH    = 5;

    localparam logic [DATA_WIDTH-1:0] ZeroWord = '0;
    localparam logic [REG_WIDTH-1:0]  ZeroReg  = '0;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP = 8'h00;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 8'h01;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 8'h02;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LB  = 8'h20;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LH  = 8'h21;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LW  = 8'h22;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LBU = 8'h23;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LHU = 8'h24;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SB  = 8'h25;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SH  = 8'h26;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SW  = 8'h27;

    localparam logic [1:0] MEM_IDLE   = 2'd0;
    localparam logic [1:0] MEM_ACCESS = 2'd1;
    localparam logic [1:0] MEM_DONE   = 2'd2;

    function automatic logic is_store_op(input logic [ALU_OP_WIDTH-1:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    function automatic logic is_mem_op(input logic [ALU_OP_WIDTH-1:0] op);
        return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
               (op == ALU_LBU) || (op == ALU_LHU) || is_store_op(op);
    endfunction

    // Index of the final byte of the access (nbytes - 1).
    function automatic logic [1:0] last_idx(input logic [ALU_OP_WIDTH-1:0] op);
        if ((op == ALU_LW) || (op == ALU_SW))
            return 2'd3;
        if ((op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH))
            return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic misaligned(input logic [ALU_OP_WIDTH-1:0] op,
                                        input logic [1:0] addr_lo);
        if ((op == ALU_LW) || (op == ALU_SW))
            return addr_lo != 2'b00;
        if ((op == ALU_LH) || (op == ALU_LHU) || (op == ALU_SH))
            return addr_lo[0];
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of an assembled load word according to the load op.
module mem_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [ALU_OP_WIDTH-1:0] op_i,
    input  logic [DATA_WIDTH-1:0]   word_i,
    output logic [DATA_WIDTH-1:0]   data_o
);

    always_comb begin
        data_o = ZeroWord;
        case (op_i)
            ALU_LB:  data_o = {{24{word_i[7]}}, word_i[7:0]};
            ALU_LBU: data_o = {24'h0, word_i[7:0]};
            ALU_LH:  data_o = {{16{word_i[15]}}, word_i[15:0]};
            ALU_LHU: data_o = {16'h0, word_i[15:0]};
            ALU_LW:  data_o = word_i;
            default: data_o = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: byte-serial load/store over a req/ack bus, stalling upstream.
// Optional MEM_MISALIGN_TRAP_EN adds misalign_o and traps unaligned H/W ops.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ex_valid_i,
    input  logic [ALU_OP_WIDTH-1:0] AluOP_i,
    input  logic [31:0]             mem_addr_i,
    input  logic [31:0]             mem_wdata_i,
    input  logic [REG_WIDTH-1:0]    rd_i,
    input  logic                    rd_op_i,
    input  logic [DATA_WIDTH-1:0]   rd_data_i,
    output logic [REG_WIDTH-1:0]    rd_o,
    output logic                    rd_op_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    valid_o,
    output logic                    stallreq_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                    misalign_o,
`endif
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic [7:0]              bus_wdata_o,
    input  logic [7:0]              bus_rdata_i,
    input  logic                    bus_ack_i
);

    logic [1:0]              state_q, state_d;
    logic [ALU_OP_WIDTH-1:0] op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [REG_WIDTH-1:0]    rd_lat_q, rd_lat_d;
    logic                    rd_op_lat_q, rd_op_lat_d;
    logic [1:0]              last_q, last_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   asm_q, asm_d;
    logic [REG_WIDTH-1:0]    rd_out_q, rd_out_d;
    logic                    rd_op_out_q, rd_op_out_d;
    logic [DATA_WIDTH-1:0]   rd_data_out_q, rd_data_out_d;
    logic                    valid_q, valid_d;
    logic                    misalign_q, misalign_d;

    logic                    in_access;
    logic                    mem_req;
    logic                    trap;
    logic [DATA_WIDTH-1:0]   asm_next;
    logic [DATA_WIDTH-1:0]   ext_data;

    assign in_access = (state_q == MEM_ACCESS);
    assign mem_req   = is_mem_op(AluOP_i);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap       = misaligned(AluOP_i, mem_addr_i[1:0]);
    assign misalign_o = misalign_q;
`else
    assign trap = 1'b0;
`endif

    // Assembly word including the byte arriving this cycle, so the final
    // byte is already visible to the extender on the DONE transition.
    always_comb begin
        asm_next = asm_q;
        if (in_access && bus_ack_i && !is_store_op(op_q))
            asm_next[{cnt_q, 3'b000} +: 8] = bus_rdata_i;
    end

    mem_load_extend u_load_extend (
        .op_i   (op_q),
        .word_i (asm_next),
        .data_o (ext_data)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rd_lat_d      = rd_lat_q;
        rd_op_lat_d   = rd_op_lat_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        asm_d         = asm_q;
        rd_out_d      = rd_out_q;
        rd_op_out_d   = rd_op_out_q;
        rd_data_out_d = rd_data_out_q;
        valid_d       = 1'b0;
        misalign_d    = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (ex_valid_i && mem_req) begin
                    op_d        = AluOP_i;
                    addr_d      = mem_addr_i[ADDR_WIDTH-1:0];
                    wdata_d     = mem_wdata_i;
                    rd_lat_d    = rd_i;
                    rd_op_lat_d = rd_op_i;
                    last_d      = last_idx(AluOP_i);
                    cnt_d       = 2'd0;
                    asm_d       = ZeroWord;
                    if (trap) begin
                        state_d       = MEM_DONE;
                        valid_d       = 1'b1;
                        misalign_d    = 1'b1;
                        rd_out_d      = rd_i;
                        rd_op_out_d   = 1'b0;
                        rd_data_out_d = ZeroWord;
                    end else begin
                        state_d = MEM_ACCESS;
                    end
                end else if (ex_valid_i) begin
                    rd_out_d      = rd_i;
                    rd_op_out_d   = rd_op_i;
                    rd_data_out_d = rd_data_i;
                    valid_d       = 1'b1;
                end
            end
            MEM_ACCESS: begin
                if (bus_ack_i) begin
                    asm_d = asm_next;
                    if (cnt_q == last_q) begin
                        state_d  = MEM_DONE;
                        valid_d  = 1'b1;
                        rd_out_d = rd_lat_q;
                        if (is_store_op(op_q)) begin
                            rd_op_out_d   = 1'b0;
                            rd_data_out_d = ZeroWord;
                        end else begin
                            rd_op_out_d   = rd_op_lat_q;
                            rd_data_out_d = ext_data;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= MEM_IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_lat_q      <= ZeroReg;
            rd_op_lat_q   <= 1'b0;
            last_q        <= 2'd0;
            cnt_q         <= 2'd0;
            asm_q         <= ZeroWord;
            rd_out_q      <= ZeroReg;
            rd_op_out_q   <= 1'b0;
            rd_data_out_q <= ZeroWord;
            valid_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_lat_q      <= rd_lat_d;
            rd_op_lat_q   <= rd_op_lat_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            asm_q         <= asm_d;
            rd_out_q      <= rd_out_d;
            rd_op_out_q   <= rd_op_out_d;
            rd_data_out_q <= rd_data_out_d;
            valid_q       <= valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign rd_o       = rd_out_q;
    assign rd_op_o    = rd_op_out_q;
    assign rd_data_o  = rd_data_out_q;
    assign valid_o    = valid_q;
    assign stallreq_o = in_access ||
                        ((state_q == MEM_IDLE) && ex_valid_i && mem_req);

    assign bus_req_o   = in_access;
    assign bus_we_o    = in_access && is_store_op(op_q);
    assign bus_addr_o  = in_access ? addr_q + ADDR_WIDTH'(cnt_q) : '0;
    assign bus_wdata_o = in_access ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit (bus responder + write-back monitor).
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_valid_i;
    logic [7:0]  AluOP_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  rd_i;
    logic        rd_op_i;
    logic [31:0] rd_data_i;
    logic [4:0]  rd_o;
    logic        rd_op_o;
    logic [31:0] rd_data_o;
    logic        valid_o;
    logic        stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [7:0]  bus_wdata_o;
    logic [7:0]  bus_rdata_i;
    logic        bus_ack_i;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic        rd_op;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   n_extra   = 0;
    int   stall_cnt = 0;

    always #5 CLK = ~CLK;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ex_valid_i  (ex_valid_i),
        .AluOP_i     (AluOP_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .rd_i        (rd_i),
        .rd_op_i     (rd_op_i),
        .rd_data_i   (rd_data_i),
        .rd_o        (rd_o),
        .rd_op_o     (rd_op_o),
        .rd_data_o   (rd_data_o),
        .valid_o     (valid_o),
        .stallreq_o  (stallreq_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o  (misalign_o),
`endif
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Write-back monitor and stall counter, sampled mid low phase.
    always @(negedge CLK) begin
        #2;
        if (stallreq_o === 1'b1)
            stall_cnt++;
        if (valid_o === 1'b1) begin
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("wb_rd", 32'(rd_o), 32'(e.rd));
                check("wb_rd_op", 32'(rd_op_o), 32'(e.rd_op));
                check("wb_data", rd_data_o, e.data);
`ifdef MEM_MISALIGN_TRAP_EN
                check("wb_misalign", 32'(misalign_o), 32'(e.mis));
`endif
            end else begin
                n_extra++;
            end
        end
    end

    task automatic issue(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic rdop, input logic [31:0] rdd);
        ex_valid_i  = 1'b1;
        AluOP_i     = op;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        rd_i        = rd;
        rd_op_i     = rdop;
        rd_data_i   = rdd;
    endtask

    task automatic serve_byte(input logic we, input logic [31:0] addr,
                              input logic [7:0] wd, input logic [7:0] rb,
                              input int delay);
        int t = 0;
        while (bus_req_o !== 1'b1 && t < 20) begin
            @(negedge CLK);
            t++;
        end
        check("bus_req", 32'(bus_req_o), 32'd1);
        if (bus_req_o !== 1'b1)
            return;
        check("bus_we", 32'(bus_we_o), 32'(we));
        check("bus_addr", bus_addr_o, addr);
        if (we)
            check("bus_wdata", 32'(bus_wdata_o), 32'(wd));
        for (int i = 0; i < delay; i++) begin
            @(negedge CLK);
            check("hold_req", 32'(bus_req_o), 32'd1);
            check("hold_addr", bus_addr_o, addr);
            check("hold_wdata", 32'(bus_wdata_o), we ? 32'(wd) : 32'd0);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = rb;
        @(negedge CLK);
        bus_ack_i   = 1'b0;
        bus_rdata_i = 8'h00;
    endtask

    task automatic run_access(input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [4:0] rd,
                              input logic st, input int nb,
                              input logic [31:0] rbytes, input int delay,
                              input logic [31:0] exp_data);
        exp_t e;
        issue(op, addr, wd, rd, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("issue_stall", 32'(stallreq_o), 32'd1);
        e.rd    = rd;
        e.rd_op = !st;
        e.data  = exp_data;
        e.mis   = 1'b0;
        sb.push_back(e);
        @(negedge CLK);
        ex_valid_i = 1'b0;
        for (int i = 0; i < nb; i++)
            serve_byte(st, addr + 32'(i), wd[8*i +: 8], rbytes[8*i +: 8], delay);
        check("done_stall", 32'(stallreq_o), 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        exp_t e;
        RST         = 1'b1;
        ex_valid_i  = 1'b0;
        AluOP_i     = ALU_NOP;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        rd_i        = '0;
        rd_op_i     = 1'b0;
        rd_data_i   = '0;
        bus_rdata_i = 8'h00;
        bus_ack_i   = 1'b0;
        repeat (2) @(negedge CLK);

        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_rd", 32'(rd_o), 32'd0);
        check("rst_rd_op", 32'(rd_op_o), 32'd0);
        check("rst_rd_data", rd_data_o, 32'd0);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_we", 32'(bus_we_o), 32'd0);
        check("rst_addr", bus_addr_o, 32'd0);
        check("rst_wdata", 32'(bus_wdata_o), 32'd0);
        RST = 1'b0;

        issue(ALU_ADD, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234);
        #1;
        check("add_stall", 32'(stallreq_o), 32'd0);
        e = '{rd: 5'd5, rd_op: 1'b1, data: 32'h0000_1234, mis: 1'b0};
        sb.push_back(e);
        @(negedge CLK);
        ex_valid_i = 1'b0;
        check("add_stall_after", 32'(stallreq_o), 32'd0);
        @(negedge CLK);

        stall_cnt = 0;
        run_access(ALU_LW, 32'h100, 32'h0, 5'd10, 1'b0, 4,
                   32'h1234_5678, 0, 32'h1234_5678);
        check("lw_stall_cycles", 32'(stall_cnt), 32'd5);

        run_access(ALU_LB, 32'h3, 32'h0, 5'd7, 1'b0, 1,
                   32'h0000_0080, 0, 32'hFFFF_FF80);
        run_access(ALU_LBU, 32'h3, 32'h0, 5'd8, 1'b0, 1,
                   32'h0000_0080, 1, 32'h0000_0080);
        run_access(ALU_LH, 32'h10, 32'h0, 5'd11, 1'b0, 2,
                   32'h0000_7FFE, 0, 32'h0000_7FFE);

`ifdef MEM_MISALIGN_TRAP_EN
        issue(ALU_LW, 32'h102, 32'h0, 5'd13, 1'b1, 32'h0);
        #1;
        check("trap_stall", 32'(stallreq_o), 32'd1);
        e = '{rd: 5'd13, rd_op: 1'b0, data: 32'h0, mis: 1'b1};
        sb.push_back(e);
        @(negedge CLK);
        ex_valid_i = 1'b0;
        check("trap_no_req", 32'(bus_req_o), 32'd0);
        @(negedge CLK);
        check("trap_no_req2", 32'(bus_req_o), 32'd0);
        check("trap_mis_clear", 32'(misalign_o), 32'd0);
        @(negedge CLK);
`else
        run_access(ALU_SH, 32'hFFFF_FFFF, 32'h0000_ABCD, 5'd9, 1'b1, 2,
                   32'h0, 3, 32'h0);
`endif

        issue(ALU_LW, 32'h200, 32'h0, 5'd12, 1'b1, 32'h0);
        #1;
        check("rst_lw_stall", 32'(stallreq_o), 32'd1);
        @(negedge CLK);
        ex_valid_i = 1'b0;
        serve_byte(1'b0, 32'h200, 8'h00, 8'h11, 0);
        check("rst_lw_byte1", bus_addr_o, 32'h201);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_req", 32'(bus_req_o), 32'd0);
        check("abort_valid", 32'(valid_o), 32'd0);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 8'hEE;
        @(negedge CLK);
        bus_ack_i   = 1'b0;
        bus_rdata_i = 8'h00;
        check("stray_ack_req", 32'(bus_req_o), 32'd0);
        check("stray_ack_stall", 32'(stallreq_o), 32'd0);
        check("stray_ack_valid", 32'(valid_o), 32'd0);

        issue(ALU_ADD, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_0055);
        #1;
        check("add2_stall", 32'(stallreq_o), 32'd0);
        e = '{rd: 5'd3, rd_op: 1'b1, data: 32'h0000_0055, mis: 1'b0};
        sb.push_back(e);
        @(negedge CLK);
        ex_valid_i = 1'b0;
        repeat (4) @(negedge CLK);
        #3;

        check("extra_wb", 32'(n_extra), 32'd0);
        check("sb_leftover", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
